// File: rtl/msf_fold_accumulator_if.sv
// Sample-side and accumulator-BRAM-side bundle of msf_fold_accumulator.
// master drives samples and BRAM read data; slave (the fold) drives addresses, strobes and wraps.
interface msf_fold_accumulator_if #(
    parameter int LEVEL_W  = 16,
    parameter int ACC_W    = 32,
    parameter int SEC_BINS = 100,
    parameter int MIN_SECS = 60
);
    localparam int SEC_AW = $clog2(SEC_BINS);
    localparam int MIN_AW = $clog2(MIN_SECS);

    logic               sample_valid;
    logic [LEVEL_W-1:0] msf_level;
    logic               sync;
    logic               clear;

    logic [SEC_AW-1:0]  sec_rd_addr;
    logic [ACC_W-1:0]   stored_level_second;
    logic               sec_wr_en;
    logic [SEC_AW-1:0]  sec_wr_addr;
    logic [ACC_W-1:0]   level_to_store_second;

    logic [MIN_AW-1:0]  min_rd_addr;
    logic [ACC_W-1:0]   stored_level_minute;
    logic               min_wr_en;
    logic [MIN_AW-1:0]  min_wr_addr;
    logic [ACC_W-1:0]   level_to_store_minute;

    logic               second_wrap;
    logic               minute_wrap;

    modport master (
        output sample_valid, msf_level, sync, clear,
        output stored_level_second, stored_level_minute,
        input  sec_rd_addr, sec_wr_en, sec_wr_addr, level_to_store_second,
        input  min_rd_addr, min_wr_en, min_wr_addr, level_to_store_minute,
        input  second_wrap, minute_wrap
    );

    modport slave (
        input  sample_valid, msf_level, sync, clear,
        input  stored_level_second, stored_level_minute,
        output sec_rd_addr, sec_wr_en, sec_wr_addr, level_to_store_second,
        output min_rd_addr, min_wr_en, min_wr_addr, level_to_store_minute,
        output second_wrap, minute_wrap
    );
endinterface

// File: rtl/msf_fold_accumulator.sv
// Folds MSF level samples into per-second and per-minute read-first BRAM accumulators (MSF_FOLD_DECAY_EN: leaky fold).
// Write strobe two edges after acceptance, one sample per cycle, no backpressure.
module msf_fold_accumulator #(
    parameter int LEVEL_W     = 16,
    parameter int ACC_W       = 32,
    parameter int SEC_BINS    = 100,
    parameter int MIN_SECS    = 60,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    msf_fold_accumulator_if.slave  bus
);
    localparam int SEC_AW = $clog2(SEC_BINS);
    localparam int MIN_AW = $clog2(MIN_SECS);
    localparam logic [SEC_AW-1:0] BIN_LAST = SEC_AW'(SEC_BINS - 1);
    localparam logic [MIN_AW-1:0] SEC_LAST = MIN_AW'(MIN_SECS - 1);

    if (ACC_W <= LEVEL_W || SEC_BINS < 2 || MIN_SECS < 2 ||
        DECAY_SHIFT < 1 || DECAY_SHIFT >= ACC_W) begin : g_bad_param
        $error("msf_fold_accumulator: illegal parameter set");
    end

    logic [SEC_AW-1:0]  r_bin_cnt;
    logic [MIN_AW-1:0]  r_sec_cnt;
    logic               r_sec_first;
    logic               r_min_first;

    logic               r_s1_vld;
    logic [LEVEL_W-1:0] r_s1_level;
    logic [SEC_AW-1:0]  r_s1_bin;
    logic [MIN_AW-1:0]  r_s1_sec;
    logic               r_s1_sec_ovr;
    logic               r_s1_min_ovr;
    logic               r_s1_swrap;
    logic               r_s1_mwrap;

    logic               r_sec_wr_en;
    logic [SEC_AW-1:0]  r_sec_wr_addr;
    logic [ACC_W-1:0]   r_sec_wr_dat;
    logic               r_min_wr_en;
    logic [MIN_AW-1:0]  r_min_wr_addr;
    logic [ACC_W-1:0]   r_min_wr_dat;
    logic               r_second_wrap;
    logic               r_minute_wrap;

    // Previous write: it lands on the same edge as the stage-1 read, which sees stale data.
    logic               r_sec_wr_en_d;
    logic [SEC_AW-1:0]  r_sec_wr_addr_d;
    logic [ACC_W-1:0]   r_sec_wr_dat_d;
    logic               r_min_wr_en_d;
    logic [MIN_AW-1:0]  r_min_wr_addr_d;
    logic [ACC_W-1:0]   r_min_wr_dat_d;

    logic [SEC_AW-1:0]  w_bin;
    logic [MIN_AW-1:0]  w_sec;
    logic               w_bin_last;
    logic               w_sec_last;
    logic [SEC_AW-1:0]  w_bin_nxt;
    logic [MIN_AW-1:0]  w_sec_nxt;
    logic [ACC_W-1:0]   w_sec_old;
    logic [ACC_W-1:0]   w_min_old;
    logic [ACC_W-1:0]   w_sec_new;
    logic [ACC_W-1:0]   w_min_new;

    function automatic logic [ACC_W-1:0] f_fold(input logic [ACC_W-1:0]   old,
                                                input logic [LEVEL_W-1:0] lvl,
                                                input logic               ovr);
        logic [ACC_W:0]   sum;
        logic [ACC_W-1:0] base;
`ifdef MSF_FOLD_DECAY_EN
        base = old - (old >> DECAY_SHIFT);
`else
        base = old;
`endif
        sum = {1'b0, base} + {{(ACC_W + 1 - LEVEL_W){1'b0}}, lvl};
        if (ovr)
            f_fold = {{(ACC_W - LEVEL_W){1'b0}}, lvl};
        else if (sum[ACC_W])
            f_fold = '1;
        else
            f_fold = sum[ACC_W-1:0];
    endfunction

    // sync places the sample presented with it at bin 0 / second 0.
    assign w_bin      = bus.sync ? '0 : r_bin_cnt;
    assign w_sec      = bus.sync ? '0 : r_sec_cnt;
    assign w_bin_last = (w_bin == BIN_LAST);
    assign w_sec_last = (w_sec == SEC_LAST);
    assign w_bin_nxt  = w_bin_last ? '0 : w_bin + 1'b1;
    assign w_sec_nxt  = w_bin_last ? (w_sec_last ? '0 : w_sec + 1'b1) : w_sec;

    assign bus.sec_rd_addr = w_bin;
    assign bus.min_rd_addr = w_sec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin_cnt   <= '0;
            r_sec_cnt   <= '0;
            r_sec_first <= 1'b1;
            r_min_first <= 1'b1;
        end else begin
            if (bus.sample_valid) begin
                r_bin_cnt <= w_bin_nxt;
                r_sec_cnt <= w_sec_nxt;
            end else if (bus.sync) begin
                r_bin_cnt <= '0;
                r_sec_cnt <= '0;
            end
            if (bus.clear) begin
                r_sec_first <= 1'b1;
                r_min_first <= 1'b1;
            end else if (bus.sample_valid && w_bin_last) begin
                r_sec_first <= 1'b0;
                if (w_sec_last)
                    r_min_first <= 1'b0;
            end
        end
    end

    // The minute word collects every bin of its second, so only bin 0 may overwrite it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld     <= 1'b0;
            r_s1_level   <= '0;
            r_s1_bin     <= '0;
            r_s1_sec     <= '0;
            r_s1_sec_ovr <= 1'b0;
            r_s1_min_ovr <= 1'b0;
            r_s1_swrap   <= 1'b0;
            r_s1_mwrap   <= 1'b0;
        end else begin
            r_s1_vld <= bus.sample_valid;
            if (bus.sample_valid) begin
                r_s1_level   <= bus.msf_level;
                r_s1_bin     <= w_bin;
                r_s1_sec     <= w_sec;
                r_s1_sec_ovr <= r_sec_first | bus.clear;
                r_s1_min_ovr <= (r_min_first | bus.clear) & (w_bin == '0);
                r_s1_swrap   <= w_bin_last;
                r_s1_mwrap   <= w_bin_last & w_sec_last;
            end
        end
    end

    always_comb begin
        w_sec_old = bus.stored_level_second;
        if (r_sec_wr_en && r_sec_wr_addr == r_s1_bin)
            w_sec_old = r_sec_wr_dat;
        else if (r_sec_wr_en_d && r_sec_wr_addr_d == r_s1_bin)
            w_sec_old = r_sec_wr_dat_d;
    end

    always_comb begin
        w_min_old = bus.stored_level_minute;
        if (r_min_wr_en && r_min_wr_addr == r_s1_sec)
            w_min_old = r_min_wr_dat;
        else if (r_min_wr_en_d && r_min_wr_addr_d == r_s1_sec)
            w_min_old = r_min_wr_dat_d;
    end

    assign w_sec_new = f_fold(w_sec_old, r_s1_level, r_s1_sec_ovr);
    assign w_min_new = f_fold(w_min_old, r_s1_level, r_s1_min_ovr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_wr_en     <= 1'b0;
            r_sec_wr_addr   <= '0;
            r_sec_wr_dat    <= '0;
            r_min_wr_en     <= 1'b0;
            r_min_wr_addr   <= '0;
            r_min_wr_dat    <= '0;
            r_second_wrap   <= 1'b0;
            r_minute_wrap   <= 1'b0;
            r_sec_wr_en_d   <= 1'b0;
            r_sec_wr_addr_d <= '0;
            r_sec_wr_dat_d  <= '0;
            r_min_wr_en_d   <= 1'b0;
            r_min_wr_addr_d <= '0;
            r_min_wr_dat_d  <= '0;
        end else begin
            r_sec_wr_en   <= r_s1_vld;
            r_min_wr_en   <= r_s1_vld;
            r_second_wrap <= r_s1_vld & r_s1_swrap;
            r_minute_wrap <= r_s1_vld & r_s1_mwrap;
            if (r_s1_vld) begin
                r_sec_wr_addr <= r_s1_bin;
                r_sec_wr_dat  <= w_sec_new;
                r_min_wr_addr <= r_s1_sec;
                r_min_wr_dat  <= w_min_new;
            end
            r_sec_wr_en_d   <= r_sec_wr_en;
            r_sec_wr_addr_d <= r_sec_wr_addr;
            r_sec_wr_dat_d  <= r_sec_wr_dat;
            r_min_wr_en_d   <= r_min_wr_en;
            r_min_wr_addr_d <= r_min_wr_addr;
            r_min_wr_dat_d  <= r_min_wr_dat;
        end
    end

    assign bus.sec_wr_en             = r_sec_wr_en;
    assign bus.sec_wr_addr           = r_sec_wr_addr;
    assign bus.level_to_store_second = r_sec_wr_dat;
    assign bus.min_wr_en             = r_min_wr_en;
    assign bus.min_wr_addr           = r_min_wr_addr;
    assign bus.level_to_store_minute = r_min_wr_dat;
    assign bus.second_wrap           = r_second_wrap;
    assign bus.minute_wrap           = r_minute_wrap;
endmodule

// File: doc/msf_fold_accumulator.md
Name: msf_fold_accumulator

Overview:
- Parametrised successor to the MSF level data-flow stage.
- Folds a stream of MSF level samples into two external read-first BRAM accumulators:
  - a per-second fold, indexed by bin within the second;
  - a per-minute fold, indexed by second within the minute.
- Performs the read-modify-write sequencing itself, with address generation, hazard forwarding, first-pass clearing and wrap flags.
- Sits between the MSF demod level output and the accumulator BRAMs read by the PS.

Parameters:
LEVEL_W, 16, width of msf_level (unsigned)
ACC_W, 32, accumulator word width (ACC_W > LEVEL_W)
SEC_BINS, 100, samples (bins) per second fold, >= 2
MIN_SECS, 60, seconds per minute fold, >= 2
DECAY_SHIFT, 4, leak shift used only when MSF_FOLD_DECAY_EN is defined (1..ACC_W-1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
sample_valid  in  1  msf_level valid this cycle
msf_level  in  LEVEL_W  level sample
sync  in  1  realign: next accepted sample goes to bin 0, second 0
clear  in  1  next fold passes overwrite instead of accumulate
sec_rd_addr  out  clog2(SEC_BINS)  second-BRAM read address (combinational from counters)
stored_level_second  in  ACC_W  second-BRAM read data, one cycle after address
sec_wr_en  out  1  second-BRAM write strobe
sec_wr_addr  out  clog2(SEC_BINS)  write address
level_to_store_second  out  ACC_W  write data
min_rd_addr  out  clog2(MIN_SECS)  minute-BRAM read address
stored_level_minute  in  ACC_W  minute-BRAM read data, one cycle after address
min_wr_en  out  1  minute-BRAM write strobe
min_wr_addr  out  clog2(MIN_SECS)  write address
level_to_store_minute  out  ACC_W  write data
second_wrap  out  1  one-cycle pulse when bin SEC_BINS-1 is written
minute_wrap  out  1  one-cycle pulse when the last bin of second MIN_SECS-1 is written

Behaviour:
- Reset (async):
  - bin_cnt = 0, sec_cnt = 0;
  - all wr_en = 0, all wr_addr = 0, write data = 0, wrap pulses = 0;
  - sec_first = 1 and min_first = 1, so the first pass after reset overwrites.
- Counters:
  - bin_cnt increments on each accepted sample; it wraps SEC_BINS-1 -> 0.
  - On that wrap, sec_cnt increments; it wraps MIN_SECS-1 -> 0.
  - Read addresses equal {bin_cnt, sec_cnt} in the cycle sample_valid is high.
- Pipeline: sample accepted at edge N.
  - Stage-1 registers level, addresses and the wrap/first flags at edge N.
  - BRAM data is used during cycle N+1.
  - wr_en, wr_addr, write data and wrap pulses are registered at edge N+1 and high for exactly one cycle.
  - Throughput: one sample per cycle. No backpressure.
- Sum:
  - new = old + zero-extended level, saturating at 2^ACC_W - 1.
  - If the fold's first flag is set, new = level (old is ignored).
- Forwarding:
  - BRAM is read-first, so a read issued in the same cycle as a write to the same address returns stale data.
  - If the stage-1 address equals the wr_addr written in the read cycle, with wr_en high, use the registered write data as old. This applies to each fold independently.
  - The minute fold hits this every sample within a second; the second fold hits it only on back-to-back same bin.
- First flags:
  - sec_first clears after the sample at bin SEC_BINS-1 is accepted.
  - min_first clears after the last sample of second MIN_SECS-1 is accepted.
  - clear sets both flags, effective from the next accepted sample.
- sync:
  - Forces bin_cnt = 0 and sec_cnt = 0 for the next accepted sample.
  - If sync and sample_valid are asserted together, the current sample is the one placed at 0/0.
  - Stage-1 samples already in flight complete normally.
  - sync does not set the first flags; accumulation continues.
- Simultaneous clear and sample_valid: that sample is already a first-pass overwrite.
- Reset mid-operation: an in-flight write is dropped and no wr_en is issued.
- Idle: wr_en and wrap pulses stay 0; write data holds its last value.

Optional Feature:
- Macro: MSF_FOLD_DECAY_EN.
- When defined:
  - both folds use leaky integration, new = old - (old >> DECAY_SHIFT) + level, saturating;
  - the first-pass overwrite still applies.
- When undefined: plain saturating accumulation. DECAY_SHIFT is unused.

Test Plan:
- SEC_BINS=4, MIN_SECS=3, reset, then 4 samples of 0x0008 -> sec writes addr 0..3 data 0x8; min addr 0 data 0x8, 0x10, 0x18, 0x20 via forwarding; second_wrap once.
- Continue 8 more samples of 0x0009, model BRAM holding prior values -> second pass writes 0x8+0x9 = 0x11 per bin; minute addr 1 and 2 reach 0x24; minute_wrap pulses once on the 12th write.
- Preload second BRAM with 0xFFFFFFFE, sample 0x000A -> level_to_store_second = 0xFFFFFFFF (saturated).
- Assert clear, then sample 0x000A at bin 0 with BRAM 0x00000111 -> writes 0x0000000A, not 0x11B.
- sync with sample_valid at bin 2 -> that sample writes sec_wr_addr 0, min_wr_addr 0; the next sample writes bin 1.
- Async reset while a write is pending -> no wr_en; outputs 0 immediately; the next sample writes bin 0 with overwrite. With MSF_FOLD_DECAY_EN, DECAY_SHIFT=4, old=0x100, level=0x8 -> 0xF8.
